// File: rtl/swa_pkg.sv
// Shared definitions for the serial word assembler and the downstream
// palindrome checker: default word width, its bit-counter width, and the
// occupancy encoding of the two-entry output holding stage.
package swa_pkg;

  localparam int WORD_W = 8;
  localparam int CNT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/swa_out_buf.sv
// Two-entry output holding stage: the head entry drives out_word/out_valid,
// the second entry (pending) absorbs one completed word while the consumer
// stalls. A write is only offered while the stage is not full.
module swa_out_buf
  import swa_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_word,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             pending_full
);

  buf_state_e       state_r;
  buf_state_e       state_nx_s;
  logic [WIDTH-1:0] out_word_r;
  logic [WIDTH-1:0] out_word_nx_s;
  logic [WIDTH-1:0] pend_word_r;
  logic [WIDTH-1:0] pend_word_nx_s;
  logic             out_valid_r;
  logic             pending_full_r;

  // Next occupancy and entry contents; pending always refills the head first.
  always_comb begin
    state_nx_s     = state_r;
    out_word_nx_s  = out_word_r;
    pend_word_nx_s = pend_word_r;
    case (state_r)
      BUF_EMPTY: begin
        if (wr_valid) begin
          state_nx_s    = BUF_ONE;
          out_word_nx_s = wr_word;
        end else begin
          state_nx_s = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (out_ready) begin
          if (wr_valid) begin
            state_nx_s    = BUF_ONE;
            out_word_nx_s = wr_word;
          end else begin
            state_nx_s = BUF_EMPTY;
          end
        end else if (wr_valid) begin
          state_nx_s     = BUF_TWO;
          pend_word_nx_s = wr_word;
        end else begin
          state_nx_s = BUF_ONE;
        end
      end
      BUF_TWO: begin
        // No write can arrive here: the upstream is held off while full.
        if (out_ready) begin
          state_nx_s    = BUF_ONE;
          out_word_nx_s = pend_word_r;
        end else begin
          state_nx_s = BUF_TWO;
        end
      end
      default: begin
        state_nx_s = BUF_EMPTY;
      end
    endcase
  end

  // Occupancy, entry storage and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= BUF_EMPTY;
      out_word_r     <= {WIDTH{1'b0}};
      pend_word_r    <= {WIDTH{1'b0}};
      out_valid_r    <= 1'b0;
      pending_full_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      out_word_r     <= out_word_nx_s;
      pend_word_r    <= pend_word_nx_s;
      out_valid_r    <= (state_nx_s != BUF_EMPTY);
      pending_full_r <= (state_nx_s == BUF_TWO);
    end
  end

  assign out_valid    = out_valid_r;
  assign out_word     = out_word_r;
  assign pending_full = pending_full_r;

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler feeding the palindrome checker.
// Accepts one bit per in_valid/in_ready handshake, builds WIDTH-bit words
// (MSB_FIRST selects bit order) and hands them to a two-entry output stage.
// Optional build macro SWA_WORD_COUNT_EN adds a 16-bit count of output
// handshakes on port word_count.
module serial_word_assembler
  import swa_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     in_ready,
  input  logic                     in_clear,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_word,
  input  logic                     out_ready,
`ifdef SWA_WORD_COUNT_EN
  output logic [15:0]              word_count,
`endif
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int                   BIT_CNT_W = $clog2(WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT  = BIT_CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]     shift_r;
  logic [WIDTH-1:0]     shift_nx_s;
  logic [BIT_CNT_W-1:0] cnt_r;
  logic                 pending_full_s;
  logic                 accept_s;
  logic                 complete_s;

  assign accept_s   = in_valid && !pending_full_s;
  assign complete_s = accept_s && !in_clear && (cnt_r == LAST_CNT);
  assign in_ready   = !pending_full_s;
  assign bit_cnt    = cnt_r;

  // Shift register contents once the current bit is inserted.
  always_comb begin
    shift_nx_s = shift_r;
    if (MSB_FIRST) begin
      shift_nx_s = {shift_r[WIDTH-2:0], in_bit};
    end else begin
      shift_nx_s = {in_bit, shift_r[WIDTH-1:1]};
    end
  end

  // Partial-word state: clear wins over a same-cycle accept; a completing
  // bit restarts the count and hands the full word to the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {BIT_CNT_W{1'b0}};
    end else if (in_clear) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {BIT_CNT_W{1'b0}};
    end else if (accept_s) begin
      if (cnt_r == LAST_CNT) begin
        shift_r <= {WIDTH{1'b0}};
        cnt_r   <= {BIT_CNT_W{1'b0}};
      end else begin
        shift_r <= shift_nx_s;
        cnt_r   <= cnt_r + BIT_CNT_W'(1);
      end
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  swa_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (complete_s),
    .wr_word     (shift_nx_s),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_word    (out_word),
    .pending_full(pending_full_s)
  );

`ifdef SWA_WORD_COUNT_EN
  logic [15:0] word_count_r;

  // Free-running count of consumer handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_r <= 16'd0;
    end else if (out_valid && out_ready) begin
      word_count_r <= word_count_r + 16'd1;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign word_count = word_count_r;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler: one MSB-first and one
// LSB-first instance share all inputs; a queue-based reference model predicts
// both, alongside a constant vector table and directed corner sequences.
module tb_serial_word_assembler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_bit;
  logic         in_clear;
  logic         out_ready;
  logic         in_ready_m, out_valid_m, in_ready_l, out_valid_l;
  logic [W-1:0] out_word_m, out_word_l;
  logic [2:0]   bit_cnt_m, bit_cnt_l;
`ifdef SWA_WORD_COUNT_EN
  logic [15:0]  wc_m, wc_l;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           part_q[$];
  logic [W-1:0] msb_q[$];
  logic [W-1:0] lsb_q[$];
  logic [15:0]  exp_wc;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_m), .in_clear(in_clear), .out_valid(out_valid_m),
    .out_word(out_word_m), .out_ready(out_ready),
`ifdef SWA_WORD_COUNT_EN
    .word_count(wc_m),
`endif
    .bit_cnt(bit_cnt_m)
  );

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_l), .in_clear(in_clear), .out_valid(out_valid_l),
    .out_word(out_word_l), .out_ready(out_ready),
`ifdef SWA_WORD_COUNT_EN
    .word_count(wc_l),
`endif
    .bit_cnt(bit_cnt_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word built from the collected bits: i-th received bit goes to W-1-i or i.
  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) r[W-1-i] = part_q[i][0];
      else     r[i]     = part_q[i][0];
    end
    return r;
  endfunction

  task automatic compare_model();
    chk("mdl_valid_m", {31'd0, out_valid_m}, {31'd0, msb_q.size() > 0});
    chk("mdl_valid_l", {31'd0, out_valid_l}, {31'd0, lsb_q.size() > 0});
    chk("mdl_ready_m", {31'd0, in_ready_m}, {31'd0, msb_q.size() < 2});
    chk("mdl_ready_l", {31'd0, in_ready_l}, {31'd0, lsb_q.size() < 2});
    chk("mdl_cnt_m", {29'd0, bit_cnt_m}, part_q.size());
    chk("mdl_cnt_l", {29'd0, bit_cnt_l}, part_q.size());
    if (msb_q.size() > 0) chk("mdl_word_m", {24'd0, out_word_m}, {24'd0, msb_q[0]});
    if (lsb_q.size() > 0) chk("mdl_word_l", {24'd0, out_word_l}, {24'd0, lsb_q[0]});
`ifdef SWA_WORD_COUNT_EN
    chk("mdl_wc_m", {16'd0, wc_m}, {16'd0, exp_wc});
    chk("mdl_wc_l", {16'd0, wc_l}, {16'd0, exp_wc});
`endif
  endtask

  // One clock: advance the model with the inputs held across the edge.
  task automatic step();
    bit drain, acc;
    @(posedge clk);
    drain = (msb_q.size() > 0) && out_ready;
    acc   = in_valid && (msb_q.size() < 2);
    if (drain) begin
      void'(msb_q.pop_front());
      void'(lsb_q.pop_front());
      exp_wc = exp_wc + 16'd1;
    end
    if (in_clear) begin
      part_q.delete();
    end else if (acc) begin
      part_q.push_back(int'(in_bit));
      if (part_q.size() == W) begin
        msb_q.push_back(pack(1'b1));
        lsb_q.push_back(pack(1'b0));
        part_q.delete();
      end
    end
    #1;
    compare_model();
  endtask

  task automatic send_word(input logic [W-1:0] val);
    for (int i = W - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = val[i];
      step();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid_m}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_m}, 32'd1);
    chk("rst_cnt", {29'd0, bit_cnt_m}, 32'd0);
    chk("rst_word", {24'd0, out_word_m}, 32'd0);
    part_q.delete();
    msb_q.delete();
    lsb_q.delete();
    exp_wc = 16'd0;
`ifdef SWA_WORD_COUNT_EN
    chk("rst_wc", {16'd0, wc_m}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic       b;
    logic       clr;
    logic       ordy;
    logic       ev;
    logic [7:0] ew;
    logic [2:0] ecnt;
    logic       erdy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_clear = 1'b0; out_ready = 1'b0;
    exp_wc = 16'd0;
    do_reset();

    // Table: 0x81 MSB-first with the consumer always ready.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd5, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd6, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd7, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 3'd0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].v; in_bit = vecs[i].b; in_clear = vecs[i].clr; out_ready = vecs[i].ordy;
      step();
      chk("tbl_valid", {31'd0, out_valid_m}, {31'd0, vecs[i].ev});
      chk("tbl_cnt", {29'd0, bit_cnt_m}, {29'd0, vecs[i].ecnt});
      chk("tbl_ready", {31'd0, in_ready_m}, {31'd0, vecs[i].erdy});
      if (vecs[i].ev) chk("tbl_word", {24'd0, out_word_m}, {24'd0, vecs[i].ew});
    end

    // Backpressure: two words held, upstream blocked, one drain frees a slot.
    out_ready = 1'b0;
    send_word(8'h12);
    send_word(8'h2F);
    chk("bp_word", {24'd0, out_word_m}, 32'h12);
    chk("bp_ready", {31'd0, in_ready_m}, 32'd0);
    chk("bp_cnt", {29'd0, bit_cnt_m}, 32'd0);
    in_valid = 1'b1; in_bit = 1'b1;
    step();
    chk("bp_blocked_cnt", {29'd0, bit_cnt_m}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_drain_word", {24'd0, out_word_m}, 32'h2F);
    chk("bp_drain_ready", {31'd0, in_ready_m}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid_m}, 32'd0);

    // Clear after 5 bits of 0xF0, then a clean 0x4E.
    for (int i = 7; i >= 3; i--) begin
      in_valid = 1'b1; in_bit = (i >= 4); step();
    end
    in_valid = 1'b0; in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    chk("clr_cnt", {29'd0, bit_cnt_m}, 32'd0);
    send_word(8'h4E);
    chk("clr_word", {24'd0, out_word_m}, 32'h4E);
    chk("clr_valid", {31'd0, out_valid_m}, 32'd1);
    step();

    // Sparse input: a gap cycle after every bit.
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] c3;
      c3 = 8'hC3;
      in_valid = 1'b1; in_bit = c3[i]; step();
      in_valid = 1'b0; if (i > 0) step();
    end
    chk("sparse_word", {24'd0, out_word_m}, 32'hC3);
    step();
    chk("sparse_once", {31'd0, out_valid_m}, 32'd0);

    // LSB-first order: bits 1,1,1,1,0,0,0,0 give 0x0F.
    send_word(8'hF0);
    chk("lsb_word", {24'd0, out_word_l}, 32'h0F);
    step();

    // Reset with a word held and a partial word in flight.
    out_ready = 1'b0;
    send_word(8'h12);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; step();
    end
    in_valid = 1'b0;
    do_reset();
    send_word(8'hA5);
    chk("rst_next_word", {24'd0, out_word_m}, 32'hA5);
    step();
    chk("rst_hold_word", {24'd0, out_word_m}, 32'hA5);
    out_ready = 1'b1;
    step();
    chk("rst_only_one", {31'd0, out_valid_m}, 32'd0);
`ifdef SWA_WORD_COUNT_EN
    chk("rst_wc_one", {16'd0, wc_m}, 32'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_bit    = $urandom_range(0, 1);
      in_clear  = ($urandom_range(0, 19) == 0);
      out_ready = $urandom_range(0, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Upstream stage of the palindrome checker.
- Receives a bit-serial stream through a valid/ready handshake and assembles WIDTH-bit words.
- Presents each completed word on a held, valid/ready-handshaked parallel output that drives the checker's num input.
- Holds one extra completed word internally, so assembly continues while the consumer stalls.

Parameters:
WIDTH, 8, word width in bits; must be at least 2.
MSB_FIRST, 1, 1 = the first received bit lands in out_word[WIDTH-1]; 0 = it lands in out_word[0].

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
in_ready  output  1  assembler accepts a bit this cycle
in_clear  input  1  synchronous abort: discard the partially assembled word
out_valid  output  1  out_word holds a complete word
out_word  output  WIDTH  assembled word, stable while out_valid=1 and out_ready=0
out_ready  input  1  consumer accepts out_word this cycle
bit_cnt  output  $clog2(WIDTH)  number of bits accepted in the current partial word

Behaviour:
- Reset (async, rst_n=0):
  - shift register, bit_cnt, out_word and pending buffer cleared to 0.
  - out_valid=0, pending_full=0.
  - in_ready goes to 1 combinationally with pending_full=0.
- Accept: a bit is taken when in_valid && in_ready at a rising edge.
  - MSB_FIRST=1: shift left, inserting at bit 0.
  - MSB_FIRST=0: shift right, inserting at bit WIDTH-1.
  - bit_cnt increments by 1.
- Completion: when the accepted bit makes bit_cnt reach WIDTH-1 → WIDTH:
  - bit_cnt wraps to 0 on the same edge.
  - The completed word (shift register plus the new bit) routes as follows:
    - If out_valid=0, or out_valid && out_ready this cycle: load into out_word; out_valid=1 next cycle.
    - Otherwise: load into the pending buffer; pending_full=1.
- Latency: out_word and out_valid are visible the cycle after the last bit is accepted.
- Drain: on out_valid && out_ready:
  - If pending_full: pending moves to out_word and out_valid stays 1.
  - Else if a word completes this same cycle: that word loads into out_word.
  - Otherwise out_valid clears to 0.
  - Pending has priority over a same-cycle completion. That case cannot arise, because in_ready=0 while pending_full.
- Flow control: in_ready = !pending_full (registered-state decode, no dependence on out_ready).
  - Bits are therefore blocked only when two complete words are held.
- in_clear=1 at an edge:
  - bit_cnt and shift register cleared.
  - Any bit accepted that same cycle is discarded.
  - out_word, out_valid and pending are untouched.
- Output stability: out_word must not change while out_valid=1 and out_ready=0.
- Reset mid-word or mid-stall: everything is discarded immediately; no partial word is ever emitted.
- in_valid=0 gaps of any length between bits are legal; assembly simply pauses.

Optional Feature:
SWA_WORD_COUNT_EN
- Defined:
  - Adds output word_count [15:0], incremented on every out_valid && out_ready handshake.
  - Wraps 0xFFFF→0x0000.
  - Reset to 0; unaffected by in_clear.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package swa_pkg:
  - constant WORD_W=8, the default for both this block and the palindrome checker.
  - localparam helper CNT_W = $clog2(WORD_W).
- One natural sub-module, swa_out_buf: the two-entry output/pending holding stage with valid/ready. The top contains the shift register, bit counter and clear logic.

Test Plan:
- MSB_FIRST=1, out_ready=1, bits 1,0,0,0,0,0,0,1 on consecutive cycles → out_word=0x81 (129), out_valid=1 exactly one cycle after 8th bit, single-cycle pulse.
- Backpressure, out_ready=0:
  - Send 0x12, then 0x2F → out_word holds 0x12.
  - pending_full, in_ready=0, bit_cnt=0.
  - Raise out_ready for one cycle → out_word=0x2F, in_ready=1 next cycle.
- Send 5 bits of 0xF0, assert in_clear for one cycle, then send 0x4E → out_word=0x4E, bit_cnt=0 after clear.
- Sparse input: in_valid toggling every other cycle, send 0xC3 → out_word=0xC3; no word lost or duplicated.
- MSB_FIRST=0: send bits 1,1,1,1,0,0,0,0 → out_word=0x0F.
- rst_n pulsed low after 3 bits of 0xFF with a word (0x12) held and out_ready=0 → out_valid=0, bit_cnt=0, in_ready=1 immediately; the next full 8 bits yield only that word. With SWA_WORD_COUNT_EN, word_count=0 after reset and =1 after the next handshake.
